// File: rtl/lane_scheduler_if.sv
// Beat/lane bus between the upstream packet source (master) and lane_scheduler (slave).
interface lane_scheduler_if #(
  parameter int numExtraction = 8,
  parameter int widthPkt      = 138,
  parameter int widthUsedw    = 6
);
  logic                                  pkt_in_valid;
  logic [widthPkt-1:0]                   pkt_in;
  logic [widthUsedw*numExtraction-1:0]   usedw_in;
  logic [numExtraction-1:0]              lane_en;
  logic [numExtraction-1:0]              wrreq_out;
  logic [widthPkt-1:0]                   data_out;
  logic                                  headerIn_enable;
  logic                                  err_nolane;
  logic [15:0]                           pkt_count;

  modport master (
    output pkt_in_valid, pkt_in, usedw_in, lane_en,
    input  wrreq_out, data_out, headerIn_enable, err_nolane, pkt_count
  );

  modport slave (
    input  pkt_in_valid, pkt_in, usedw_in, lane_en,
    output wrreq_out, data_out, headerIn_enable, err_nolane, pkt_count
  );
endinterface

// File: rtl/lane_scheduler.sv
// Round-robin packet-to-lane dispatcher with per-lane fill threshold and drop path.
// Define LANE_SCHED_CNT_EN to build the dispatched-packet counter (pkt_count).
module lane_scheduler #(
  parameter int numExtraction = 8,
  parameter int widthPkt      = 138,
  parameter int widthUsedw    = 6,
  parameter int thresh        = 50
) (
  input logic             clk,
  input logic             reset,
  lane_scheduler_if.slave bus
);
  localparam int PTR_W = (numExtraction > 1) ? $clog2(numExtraction) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         held;
  logic [numExtraction-1:0] wrreq_r;
  logic [widthPkt-1:0]      data_r;
  logic                     hie_r;
  logic                     err_r;

  logic [widthUsedw-1:0]    usedw [numExtraction];
  logic [numExtraction-1:0] eligible;
  logic                     any_elig;
  logic                     held_ok;
  logic                     grant_found;
  logic [PTR_W-1:0]         grant_idx;
  logic                     is_tail;
  logic                     tail_fwd;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == numExtraction - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < numExtraction; i++) begin
      usedw[i]    = bus.usedw_in[i*widthUsedw +: widthUsedw];
      eligible[i] = bus.lane_en[i] && (int'(usedw[i]) < thresh);
    end
  end

  assign any_elig = |eligible;
  assign held_ok  = int'(usedw[held]) < thresh;
  assign is_tail  = bus.pkt_in[129:128] == 2'b01;
  assign tail_fwd = bus.pkt_in_valid && is_tail &&
                    ((state == IDLE && any_elig) || state == FWD);

  // First eligible lane at or after rr_ptr, wrapping past the top lane.
  always_comb begin
    logic [PTR_W-1:0] cand_idx;
    int unsigned      cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < numExtraction; k++) begin
      cand     = (32'(rr_ptr) + k) % numExtraction;
      cand_idx = PTR_W'(cand);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      held    <= '0;
      wrreq_r <= '0;
      data_r  <= '0;
      hie_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      wrreq_r <= '0;
      if (tail_fwd)
        rr_ptr <= inc_ptr(state == IDLE ? grant_idx : held);
      case (state)
        IDLE: begin
          hie_r <= any_elig;
          if (bus.pkt_in_valid) begin
            if (grant_found) begin
              data_r  <= bus.pkt_in;
              wrreq_r <= numExtraction'(1) << grant_idx;
              held    <= grant_idx;
              state   <= is_tail ? IDLE : FWD;
            end else begin
              err_r <= 1'b1;
              state <= is_tail ? IDLE : DROP;
            end
          end
        end
        FWD: begin
          // Held lane keeps the packet even if it becomes ineligible.
          hie_r <= held_ok;
          if (bus.pkt_in_valid) begin
            data_r  <= bus.pkt_in;
            wrreq_r <= numExtraction'(1) << held;
            if (is_tail)
              state <= IDLE;
          end
        end
        default: begin
          hie_r <= 1'b1;
          if (bus.pkt_in_valid && is_tail)
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef LANE_SCHED_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (tail_fwd)
      cnt <= cnt + 16'd1;
  end
  assign bus.pkt_count = cnt;
`else
  assign bus.pkt_count = '0;
`endif

  assign bus.wrreq_out       = wrreq_r;
  assign bus.data_out        = data_r;
  assign bus.headerIn_enable = hie_r;
  assign bus.err_nolane      = err_r;
endmodule

// File: tb/tb_lane_scheduler.sv
// Directed testbench for lane_scheduler: grant order, thresholds, drop path, reset.
module tb_lane_scheduler;
  localparam int N  = 8;
  localparam int W  = 138;
  localparam int UW = 6;
  localparam int TH = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_scheduler_if #(.numExtraction(N), .widthPkt(W), .widthUsedw(UW)) bus();

  lane_scheduler #(.numExtraction(N), .widthPkt(W), .widthUsedw(UW), .thresh(TH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [W-1:0] last_fwd = '0;

  function automatic logic [W-1:0] mk_beat(input bit tail, input logic [31:0] tag);
    logic [W-1:0] b;
    b = '0;
    b[129:128] = tail ? 2'b01 : 2'b10;
    b[31:0] = tag;
    b[137:130] = tag[7:0] ^ 8'hA5;
    return b;
  endfunction

  function automatic logic [15:0] cnt_exp();
`ifdef LANE_SCHED_CNT_EN
    return 16'(exp_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit tail, input logic [31:0] tag);
    bus.pkt_in_valid = v;
    bus.pkt_in = mk_beat(tail, tag);
  endtask

  task automatic set_usedw(input int lane, input int val);
    bus.usedw_in[lane*UW +: UW] = UW'(val);
  endtask

  task automatic chk_strobe(input string name, input logic [N-1:0] exp_w, input logic [W-1:0] exp_d);
    tests++;
    if (bus.wrreq_out !== exp_w) begin
      fails++;
      $display("FAIL %s wrreq: got %h expected %h", name, bus.wrreq_out, exp_w);
    end
    tests++;
    if (bus.data_out !== exp_d) begin
      fails++;
      $display("FAIL %s data: got %h expected %h", name, bus.data_out, exp_d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.lane_en = '1;
    bus.usedw_in = '0;
    drive(1, 0, 32'hDEAD);
    tick();
    tick();
    tests++; if (bus.wrreq_out !== 8'h00) begin fails++; $display("FAIL reset wrreq: got %h expected 00", bus.wrreq_out); end
    tests++; if (bus.data_out !== '0) begin fails++; $display("FAIL reset data: got %h expected 0", bus.data_out); end
    tests++; if (bus.headerIn_enable !== 1'b0) begin fails++; $display("FAIL reset hie: got %b expected 0", bus.headerIn_enable); end
    tests++; if (bus.err_nolane !== 1'b0) begin fails++; $display("FAIL reset err: got %b expected 0", bus.err_nolane); end
    tests++; if (bus.pkt_count !== 16'h0) begin fails++; $display("FAIL reset cnt: got %h expected 0", bus.pkt_count); end
    reset = 1'b0;
    drive(0, 0, 32'h0);
    tick();
    tests++; if (bus.headerIn_enable !== 1'b1) begin fails++; $display("FAIL post-reset hie: got %b expected 1", bus.headerIn_enable); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] b;
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < 3; k++) begin
        b = mk_beat(k == 2, 32'(p*16 + k));
        drive(1, k == 2, 32'(p*16 + k));
        tick();
        chk_strobe("rr", N'(1) << p, b);
        tests++;
        if (bus.headerIn_enable !== 1'b1) begin
          fails++; $display("FAIL rr hie p%0d b%0d: got %b expected 1", p, k, bus.headerIn_enable);
        end
        last_fwd = b;
      end
      exp_cnt++;
    end
    drive(0, 0, 32'h77);
    tick();
    chk_strobe("rr idle", 8'h00, last_fwd);
    tests++; if (bus.pkt_count !== cnt_exp()) begin fails++; $display("FAIL rr cnt: got %0d expected %0d", bus.pkt_count, cnt_exp()); end
  endtask

  task automatic test_single_beat();
    drive(1, 1, 32'h100); tick(); chk_strobe("single A", 8'h01, mk_beat(1, 32'h100));
    drive(1, 1, 32'h101); tick(); chk_strobe("single B", 8'h02, mk_beat(1, 32'h101));
    last_fwd = mk_beat(1, 32'h101);
    exp_cnt += 2;
    drive(0, 0, 32'h0); tick(); chk_strobe("single idle", 8'h00, last_fwd);
    tests++; if (bus.pkt_count !== cnt_exp()) begin fails++; $display("FAIL single cnt: got %0d expected %0d", bus.pkt_count, cnt_exp()); end
  endtask

  task automatic test_skip_full();
    set_usedw(2, 50);
    drive(1, 0, 32'h200); tick(); chk_strobe("skip head", 8'h08, mk_beat(0, 32'h200));
    drive(1, 1, 32'h201); tick(); chk_strobe("skip tail", 8'h08, mk_beat(1, 32'h201));
    set_usedw(2, 0);
    set_usedw(4, 49);
    drive(1, 1, 32'h202); tick(); chk_strobe("thresh-1 lane4", 8'h10, mk_beat(1, 32'h202));
    set_usedw(4, 0);
    bus.lane_en = 8'h1F;
    drive(1, 1, 32'h203); tick(); chk_strobe("wrap lane0", 8'h01, mk_beat(1, 32'h203));
    bus.lane_en = 8'hFF;
    last_fwd = mk_beat(1, 32'h203);
    exp_cnt += 3;
    drive(0, 0, 32'h0); tick(); chk_strobe("skip idle", 8'h00, last_fwd);
  endtask

  task automatic test_held_full();
    drive(1, 0, 32'h300); tick(); chk_strobe("held b1", 8'h02, mk_beat(0, 32'h300));
    tests++; if (bus.headerIn_enable !== 1'b1) begin fails++; $display("FAIL held hie b1: got %b expected 1", bus.headerIn_enable); end
    set_usedw(1, 50);
    drive(1, 0, 32'h301); tick(); chk_strobe("held b2", 8'h02, mk_beat(0, 32'h301));
    tests++; if (bus.headerIn_enable !== 1'b0) begin fails++; $display("FAIL held hie b2: got %b expected 0", bus.headerIn_enable); end
    bus.lane_en = 8'h00;
    drive(1, 0, 32'h302); tick(); chk_strobe("held b3 lanes off", 8'h02, mk_beat(0, 32'h302));
    bus.lane_en = 8'hFF;
    drive(1, 1, 32'h303); tick(); chk_strobe("held tail", 8'h02, mk_beat(1, 32'h303));
    tests++; if (bus.headerIn_enable !== 1'b0) begin fails++; $display("FAIL held hie tail: got %b expected 0", bus.headerIn_enable); end
    last_fwd = mk_beat(1, 32'h303);
    exp_cnt++;
    drive(0, 0, 32'h0); tick(); chk_strobe("held idle", 8'h00, last_fwd);
    tests++; if (bus.headerIn_enable !== 1'b1) begin fails++; $display("FAIL held hie idle: got %b expected 1", bus.headerIn_enable); end
    set_usedw(1, 0);
  endtask

  task automatic test_drop();
    logic exp_hie [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bus.lane_en = 8'h00;
    drive(0, 0, 32'h0); tick();
    tests++; if (bus.headerIn_enable !== 1'b0) begin fails++; $display("FAIL drop hie pre: got %b expected 0", bus.headerIn_enable); end
    tests++; if (bus.err_nolane !== 1'b0) begin fails++; $display("FAIL drop err pre: got %b expected 0", bus.err_nolane); end
    for (int k = 0; k < 4; k++) begin
      drive(1, k == 3, 32'(32'h400 + k)); tick();
      chk_strobe("drop beat", 8'h00, last_fwd);
      tests++; if (bus.headerIn_enable !== exp_hie[k]) begin fails++; $display("FAIL drop hie b%0d: got %b expected %b", k, bus.headerIn_enable, exp_hie[k]); end
      tests++; if (bus.err_nolane !== 1'b1) begin fails++; $display("FAIL drop err b%0d: got %b expected 1", k, bus.err_nolane); end
    end
    drive(0, 0, 32'h0); tick();
    chk_strobe("drop idle", 8'h00, last_fwd);
    tests++; if (bus.headerIn_enable !== 1'b0) begin fails++; $display("FAIL drop hie post: got %b expected 0", bus.headerIn_enable); end
    tests++; if (bus.pkt_count !== cnt_exp()) begin fails++; $display("FAIL drop cnt: got %0d expected %0d", bus.pkt_count, cnt_exp()); end
    // dropped single-beat packet must leave the FSM in IDLE
    drive(1, 1, 32'h410); tick(); chk_strobe("drop single", 8'h00, last_fwd);
    bus.lane_en = 8'hFF;
    drive(1, 1, 32'h411); tick(); chk_strobe("after drop lane2", 8'h04, mk_beat(1, 32'h411));
    tests++; if (bus.err_nolane !== 1'b1) begin fails++; $display("FAIL err sticky: got %b expected 1", bus.err_nolane); end
    last_fwd = mk_beat(1, 32'h411);
    exp_cnt++;
    drive(0, 0, 32'h0); tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(1, 0, 32'h500); tick(); chk_strobe("rst-mid b1", 8'h08, mk_beat(0, 32'h500));
    reset = 1'b1;
    drive(1, 0, 32'h501); tick();
    chk_strobe("rst-mid during", 8'h00, '0);
    tests++; if (bus.err_nolane !== 1'b0) begin fails++; $display("FAIL rst-mid err: got %b expected 0", bus.err_nolane); end
    tests++; if (bus.pkt_count !== 16'h0) begin fails++; $display("FAIL rst-mid cnt: got %h expected 0", bus.pkt_count); end
    reset = 1'b0;
    exp_cnt = 0;
    drive(1, 0, 32'h502); tick(); chk_strobe("rst-mid new head", 8'h01, mk_beat(0, 32'h502));
    drive(1, 0, 32'h503); tick(); chk_strobe("rst-mid b4", 8'h01, mk_beat(0, 32'h503));
    drive(1, 1, 32'h504); tick(); chk_strobe("rst-mid tail", 8'h01, mk_beat(1, 32'h504));
    exp_cnt++;
    last_fwd = mk_beat(1, 32'h504);
    drive(0, 0, 32'h0); tick(); chk_strobe("rst-mid idle", 8'h00, last_fwd);
    tests++; if (bus.pkt_count !== cnt_exp()) begin fails++; $display("FAIL rst-mid final cnt: got %0d expected %0d", bus.pkt_count, cnt_exp()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_beat();
    test_skip_full();
    test_held_full();
    test_drop();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lane_scheduler.md
LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 Parameters SHALL be: numExtraction, 8, number of extraction lanes; widthPkt, 138, beat width; widthUsedw, 6, lane FIFO fill-count width; thresh, 50, per-lane fill limit.
REQ-002 Port clk SHALL be input, width 1, the single clock; all logic is on its rising edge.
REQ-003 Port reset SHALL be input, width 1, synchronous active-high reset.
REQ-004 Port pkt_in_valid SHALL be input, width 1, beat valid.
REQ-005 Port pkt_in SHALL be input, width widthPkt, beat; bits [129:128]==2'b01 mark the tail beat.
REQ-006 Port usedw_in SHALL be input, width widthUsedw*numExtraction, lane i fill count at [i*widthUsedw +: widthUsedw].
REQ-007 Port lane_en SHALL be input, width numExtraction, per-lane enable mask.
REQ-008 Port wrreq_out SHALL be output, width numExtraction, one-hot lane FIFO write strobe.
REQ-009 Port data_out SHALL be output, width widthPkt, registered copy of the beat.
REQ-010 Port headerIn_enable SHALL be output, width 1, registered upstream permit.
REQ-011 Port err_nolane SHALL be output, width 1, sticky flag for a dropped packet.
REQ-012 Port pkt_count SHALL be output, width 16, count of dispatched packets.

Function
REQ-013 Lane i SHALL be eligible when lane_en[i]==1 and usedw of lane i < thresh.
REQ-014 The FSM SHALL have three states: IDLE, FWD and DROP.
REQ-015 In IDLE, a valid beat SHALL be granted to the first eligible lane at or after rr_ptr, searching upward with wrap from numExtraction-1 to 0.
REQ-016 A granted beat SHALL appear on data_out, with wrreq_out equal to the one-hot grant, exactly 1 cycle after acceptance; the state then moves to FWD.
REQ-017 A granted beat carrying the tail tag (single-beat packet) SHALL leave the state in IDLE.
REQ-018 In FWD, every valid beat SHALL be forwarded to the held lane with 1-cycle latency, regardless of that lane's eligibility.
REQ-019 In FWD, the tail beat SHALL return the state to IDLE.
REQ-020 On each tail beat forwarded, rr_ptr SHALL be set to (granted lane + 1) mod numExtraction.
REQ-021 On each tail beat forwarded, pkt_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-022 In IDLE, a valid beat with no eligible lane SHALL set err_nolane and be dropped.
REQ-023 For such a dropped beat, the state SHALL move to DROP unless the beat is a tail.
REQ-024 In DROP, beats SHALL be discarded with wrreq_out=0; the tail beat SHALL return the state to IDLE.
REQ-025 In DROP, rr_ptr and pkt_count SHALL be unchanged.
REQ-026 In any cycle without a forwarded beat, wrreq_out SHALL be 0 and data_out SHALL hold its last value.
REQ-027 headerIn_enable SHALL be registered: 1 in the cycle after (IDLE and at least one eligible lane), (FWD and held lane usedw < thresh), or DROP; otherwise 0.
REQ-028 Valid beats SHALL be processed even when headerIn_enable==0; upstream absorbs the 1-cycle lag, and the thresh margin covers it.
REQ-029 lane_en changes SHALL affect only the next grant decision, never a packet already in FWD.
REQ-030 err_nolane SHALL remain set until reset.

Reset
REQ-031 When reset is high at a clock edge: state=IDLE, rr_ptr=0, wrreq_out=0, data_out=0, headerIn_enable=0, err_nolane=0, pkt_count=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; post-reset beats SHALL be treated as new packet heads.

Configuration
REQ-033 Macro LANE_SCHED_CNT_EN SHALL control the packet counter.
REQ-034 With LANE_SCHED_CNT_EN defined, pkt_count SHALL behave per REQ-021.
REQ-035 Without LANE_SCHED_CNT_EN, pkt_count SHALL be constant 0 with no counter register; all other behaviour is identical.

Verification
REQ-036 Scenario 1: all usedw=0, lane_en=8'hFF, eight 3-beat packets -> wrreq_out one-hot sequence 01,02,04,...,80, each strobe for 3 cycles, pkt_count=8.
REQ-037 Scenario 2: lane 2 usedw=50, rr_ptr=2, one packet -> granted to lane 3 (wrreq_out=8'h08).
REQ-038 Scenario 3: lane_en=8'h00, one 4-beat packet -> err_nolane=1, no wrreq_out strobe, then state IDLE and headerIn_enable=0.
REQ-039 Scenario 4: held lane usedw rises to 50 mid-packet -> headerIn_enable falls 1 cycle later, remaining valid beats still go to the same lane.
REQ-040 Scenario 5: reset pulsed on beat 2 of a 5-beat packet, next beat sent -> it is granted to lane 0 as a new packet.
REQ-041 Scenario 6: single-beat packet with tag 2'b01, then a second packet -> lane 0 then lane 1, each strobe lasts 1 cycle.
